rs_encoder_15_11: RTL and testbench
===================================

# rs_encoder_15_11

Systematic Reed-Solomon RS(15,11) encoder over GF(16), primitive polynomial x^4+x+1, roots α^1..α^4. Sits directly downstream of the 4-bit message source. It accepts 11 message symbols serially and emits a 15-symbol codeword, one symbol per clock: the 11 message symbols pass through unchanged, followed by 4 parity symbols. Its output feeds the channel/decoder stage.

## Interface
- No parameters. N=15, K=11, NPAR=4 and the generator coefficients are fixed constants in the shared package.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  [0:3]  message symbol; bit 0 = coefficient of x^0 (4'b1000 = α^0, 4'b1100 = α^4).
- in_valid  input  1  data_in is valid this cycle.
- in_ready  output  1  encoder can accept a symbol this cycle.
- code_out  output  [0:3]  codeword symbol, same bit mapping as data_in.
- code_valid  output  1  code_out is valid.
- code_sop  output  1  first symbol of codeword (with code_valid).
- code_eop  output  1  last parity symbol (with code_valid).
- end_of_work  output  1  one-cycle pulse, the cycle after code_eop.

## Operation
- Generator: g(x) = x^4 + α^13·x^3 + α^6·x^2 + α^3·x + α^10; constants G3=4'b1011, G2=4'b0011, G1=4'b0001, G0=4'b1110.
- Parity registers r0..r3 (4 bits each); symbol counter cnt 0..10 (4 bits); parity counter pcnt 0..3.
- FSM states:
  - IDLE: in_ready=1. On an accepted symbol (in_valid && in_ready), go to DATA with cnt=1.
  - DATA: in_ready=1. Each accepted symbol increments cnt. When the 11th symbol is accepted, go to PARITY with pcnt=0.
  - PARITY: in_ready=0. Emit r3 and shift r3←r2, r2←r1, r1←r0, r0←0. After 4 symbols, go to DONE.
  - DONE: in_ready=0. end_of_work=1 for this one cycle, then return to IDLE.
- Per accepted symbol d: fb = d ⊕ r3; r3←r2⊕fb·G3; r2←r1⊕fb·G2; r1←r0⊕fb·G1; r0←fb·G0. code_out←d, code_valid←1.
- The first accepted symbol of a codeword is computed with r0..r3 cleared (registers are zeroed on DONE→IDLE), and sets code_sop.
- GF(16) multiply by a constant is pure XOR logic. Addition is XOR. No carries; widths stay 4 bits.
- in_valid low in DATA is a stall: registers and cnt hold, code_valid=0 next cycle. Gaps are unlimited.
- in_valid in PARITY or DONE is ignored and the symbol is dropped. Upstream must honour in_ready.
- Reset (any state, including mid-codeword): state=IDLE, r0..r3=0, cnt=pcnt=0, code_out=4'b0000, code_valid=code_sop=code_eop=end_of_work=0. in_ready=1 once reset is released. A partial codeword is discarded and never completed.

## Timing
- All outputs are registered. A symbol accepted at edge k appears on code_out after edge k (latency 1).
- Gapless input, first symbol accepted at edge t: code_valid is high for 15 consecutive cycles after edges t..t+14.
  - code_sop is high after edge t.
  - Parity order is α^… highest degree first: r3, r2, r1, r0, after edges t+11..t+14.
  - code_eop is high after edge t+14.
  - end_of_work is high after edge t+15.
  - in_ready is high again after edge t+16.
- Minimum codeword period: 17 cycles.
- Simultaneous reset deassertion and in_valid: the symbol is not accepted on the first edge after release.

## Structure
- Package rs_gf16_pkg holds:
  - constants N, K, NPAR, G0..G3;
  - state enum {IDLE, DATA, PARITY, DONE};
  - function gf16_mul_const (generic GF(16) multiply, reduction by x^4+x+1). The bench reuses it for its reference model.
- One sub-module is natural: rs_gf16_lfsr. It holds r0..r3, with ports for shift enable, feedback-enable (data vs. parity mode), clear, and symbol input/r3 output. The FSM and counters stay in the top.

## Test plan
- Reset, then 10×4'b0000 followed by 4'b1000 (α^0) gapless -> 11 data symbols echoed, then parity 4'b1011, 4'b0011, 4'b0001, 4'b1110. code_sop on the 1st output, code_eop on the 15th.
- 10×zero followed by 4'b0010 (α^2) -> parity 4'b1000, 4'b1010, 4'b0110, 4'b1111.
- Source message α^0, α^1, α^4, α^2, α^8, α^5, α^10, α^3, α^14, α^9, α^7, with random in_valid gaps -> data echoed in order. Syndromes S1..S4 of the 15-symbol output, computed by the bench, are all 4'b0000. Output is identical to the gapless run.
- in_valid held high continuously for 40 cycles with random data -> exactly 2 codewords of 15 symbols, plus a partial one in progress. Symbols offered in PARITY/DONE are dropped. end_of_work pulses once per codeword.
- rst_n asserted after the 6th accepted symbol -> all outputs 0 asynchronously. The next full message encodes identically to a fresh-reset run.
- All-zero message -> 15 zero symbols with code_valid high, and sop/eop still correctly placed.

Source files
------------

// File: rtl/rs_gf16_pkg.sv
// Shared constants, FSM encoding and GF(16) arithmetic for the RS(15,11) encoder.
// Symbol bit mapping everywhere: index 0 of a [0:3] vector is the x^0 coefficient.
package rs_gf16_pkg;

  localparam int N    = 15;
  localparam int K    = 11;
  localparam int NPAR = 4;

  // g(x) = x^4 + a^13 x^3 + a^6 x^2 + a^3 x + a^10
  localparam logic [0:3] G3 = 4'b1011;
  localparam logic [0:3] G2 = 4'b0011;
  localparam logic [0:3] G1 = 4'b0001;
  localparam logic [0:3] G0 = 4'b1110;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;

  // Generic GF(16) product, reduced modulo x^4 + x + 1. With one operand a
  // constant this collapses to a handful of XOR gates after synthesis.
  function automatic logic [0:3] gf16_mul_const(input logic [0:3] a, input logic [0:3] b);
    logic [0:6] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        p[i+j] = p[i+j] ^ (a[i] & b[j]);
    // fold x^6, x^5, x^4 down using x^4 = x + 1
    for (int k = 6; k >= 4; k--) begin
      if (p[k]) begin
        p[k-4] = ~p[k-4];
        p[k-3] = ~p[k-3];
        p[k]   = 1'b0;
      end
    end
    return p[0:3];
  endfunction

endpackage

// File: rtl/rs_gf16_lfsr.sv
// Parity LFSR for the RS(15,11) encoder: divides the shifted message by g(x).
// fb_en=1 absorbs a message symbol; fb_en=0 just shifts the parity out via r3.
module rs_gf16_lfsr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       fb_en,
  input  logic [0:3] sym_in,
  output logic [0:3] r3_out
);
  import rs_gf16_pkg::*;

  logic [0:3] r0, r1, r2, r3;
  logic [0:3] fb;

  // Forcing feedback to zero turns the division step into a plain shift.
  assign fb     = fb_en ? (sym_in ^ r3) : 4'b0000;
  assign r3_out = r3;

  // Remainder registers: cleared between codewords, updated one symbol per shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0 <= 4'b0000;
      r1 <= 4'b0000;
      r2 <= 4'b0000;
      r3 <= 4'b0000;
    end else if (clear) begin
      r0 <= 4'b0000;
      r1 <= 4'b0000;
      r2 <= 4'b0000;
      r3 <= 4'b0000;
    end else if (shift_en) begin
      r3 <= r2 ^ gf16_mul_const(fb, G3);
      r2 <= r1 ^ gf16_mul_const(fb, G2);
      r1 <= r0 ^ gf16_mul_const(fb, G1);
      r0 <= gf16_mul_const(fb, G0);
    end
  end

endmodule

// File: rtl/rs_encoder_15_11.sv
// Systematic RS(15,11) encoder over GF(16). Echoes 11 message symbols with one
// cycle of latency, then emits 4 parity symbols (r3 first), then a one-cycle
// end_of_work pulse. Minimum codeword period is 17 cycles.
module rs_encoder_15_11 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:3] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [0:3] code_out,
  output logic       code_valid,
  output logic       code_sop,
  output logic       code_eop,
  output logic       end_of_work
);
  import rs_gf16_pkg::*;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [1:0] pcnt, pcnt_nx;
  logic       armed;
  logic       accept;
  logic       shift_en, fb_en, clear;
  logic [0:3] parity_sym;
  logic [0:3] out_nx;
  logic       valid_nx, sop_nx, eop_nx, eow_nx;

  // in_ready depends only on registered state; armed keeps the first edge
  // after reset release from taking a symbol.
  assign in_ready = armed && (state == IDLE || state == DATA);
  assign accept   = in_valid && in_ready;

  rs_gf16_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (shift_en),
    .fb_en    (fb_en),
    .sym_in   (data_in),
    .r3_out   (parity_sym)
  );

  // One-edge arming flag after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // FSM state and symbol/parity counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      pcnt  <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pcnt  <= pcnt_nx;
    end
  end

  // Next-state, LFSR control and next values of the registered outputs.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pcnt_nx  = pcnt;
    shift_en = 1'b0;
    fb_en    = 1'b0;
    clear    = 1'b0;
    out_nx   = 4'b0000;
    valid_nx = 1'b0;
    sop_nx   = 1'b0;
    eop_nx   = 1'b0;
    eow_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_en = 1'b1;
          fb_en    = 1'b1;
          out_nx   = data_in;
          valid_nx = 1'b1;
          sop_nx   = 1'b1;
          cnt_nx   = 4'd1;
          state_nx = DATA;
        end
      end
      DATA: begin
        // a cycle without in_valid is a stall: nothing moves
        if (accept) begin
          shift_en = 1'b1;
          fb_en    = 1'b1;
          out_nx   = data_in;
          valid_nx = 1'b1;
          if (cnt == 4'(K - 1)) begin
            cnt_nx   = 4'd0;
            pcnt_nx  = 2'd0;
            state_nx = PARITY;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        // code_eop already high means the last parity symbol went out
        if (code_eop) begin
          eow_nx   = 1'b1;
          pcnt_nx  = 2'd0;
          state_nx = DONE;
        end else begin
          shift_en = 1'b1;
          out_nx   = parity_sym;
          valid_nx = 1'b1;
          eop_nx   = (pcnt == 2'(NPAR - 1));
          pcnt_nx  = pcnt + 2'd1;
        end
      end
      DONE: begin
        clear    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_out    <= 4'b0000;
      code_valid  <= 1'b0;
      code_sop    <= 1'b0;
      code_eop    <= 1'b0;
      end_of_work <= 1'b0;
    end else begin
      code_out    <= out_nx;
      code_valid  <= valid_nx;
      code_sop    <= sop_nx;
      code_eop    <= eop_nx;
      end_of_work <= eow_nx;
    end
  end

endmodule

// File: tb/tb_rs_encoder_15_11.sv
// Self-checking bench for rs_encoder_15_11: scoreboard fed by a polynomial
// long-division reference, syndrome checks, timing and reset checks.
module tb_rs_encoder_15_11;
  import rs_gf16_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:3] data_in = 4'b0000;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [0:3] code_out;
  logic       code_valid, code_sop, code_eop, end_of_work;

  rs_encoder_15_11 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .code_sop    (code_sop),
    .code_eop    (code_eop),
    .end_of_work (end_of_work)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_eop = 0, n_eow = 0, n_acc = 0, n_vld = 0;
  int acc_cyc = 0, sop_cyc = 0, eop_cyc = 0, eow_cyc = 0;

  logic [5:0] exp_q[$];   // {symbol, sop, eop}
  logic [0:3] msg_q[$];   // accepted symbols of the current message
  logic [0:3] got_q[$];   // observed symbols of the current codeword
  logic [0:3] last_cw[N];
  logic [0:3] ref_cw[N];

  logic [0:3] msg[K];
  logic [0:3] msg3[K] = '{4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b1010, 4'b0110,
                          4'b1110, 4'b0001, 4'b1001, 4'b0101, 4'b1101};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: remainder of m(x)*x^4 divided by g(x), by long division.
  task automatic push_parity();
    logic [0:3] rem[N];
    logic [0:3] g[NPAR+1];
    logic [0:3] c;
    g = '{4'b1000, G3, G2, G1, G0};
    for (int i = 0; i < N; i++) rem[i] = (i < K) ? msg_q[i] : 4'b0000;
    for (int i = 0; i < K; i++) begin
      c = rem[i];
      for (int j = 0; j <= NPAR; j++) rem[i+j] = rem[i+j] ^ gf16_mul_const(c, g[j]);
    end
    for (int j = 0; j < NPAR; j++) exp_q.push_back({rem[K+j], 1'b0, 1'(j == NPAR - 1)});
  endtask

  // One clock: note acceptance, then observe registered outputs after the edge.
  task automatic step();
    logic       acc;
    logic [0:3] d;
    logic [5:0] e;
    acc = in_valid && in_ready && rst_n;
    d   = data_in;
    @(posedge clk); #1;
    cyc++;
    if (acc) begin
      if (msg_q.size() == 0) acc_cyc = cyc;
      exp_q.push_back({d, 1'(msg_q.size() == 0), 1'b0});
      msg_q.push_back(d);
      n_acc++;
      if (msg_q.size() == K) begin
        push_parity();
        msg_q.delete();
      end
    end
    if (code_valid) begin
      n_vld++;
      if (exp_q.size() == 0) check("unexpected_sym", code_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("sym_sop_eop", {code_out, code_sop, code_eop}, e);
      end
      if (code_sop) begin got_q.delete(); sop_cyc = cyc; end
      got_q.push_back(code_out);
      if (code_eop) begin
        n_eop++;
        eop_cyc = cyc;
        check("cw_len", got_q.size(), N);
        if (got_q.size() == N) for (int i = 0; i < N; i++) last_cw[i] = got_q[i];
      end
    end
    if (end_of_work) begin n_eow++; eow_cyc = cyc; end
  endtask

  task automatic send_msg(input logic [0:3] m[K], input int gap_pct);
    int i = 0, budget = 0;
    while (i < K && budget < 400) begin
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        data_in  = 4'($urandom);
      end else begin
        in_valid = 1'b1;
        data_in  = m[i];
        if (in_ready) i++;
      end
      step();
      budget++;
    end
    in_valid = 1'b0;
    if (i < K) check("send_timeout", i, K);
  endtask

  // Run to end_of_work, then check the ready turnaround and pulse width.
  task automatic drain(input string tag);
    int b = 0, e0 = n_eow;
    while (n_eow == e0 && b < 60) begin step(); b++; end
    if (n_eow == e0) check({tag, "_drain_timeout"}, n_eow, e0 + 1);
    check({tag, "_rdy_in_done"}, in_ready, 1'b0);
    step();
    check({tag, "_eow_pulse"}, end_of_work, 1'b0);
    check({tag, "_rdy_back"}, in_ready, 1'b1);
  endtask

  task automatic check_syndromes(input string tag);
    logic [0:3] ap[NPAR];
    logic [0:3] s;
    ap = '{4'b0100, 4'b0010, 4'b0001, 4'b1100};
    for (int j = 0; j < NPAR; j++) begin
      s = 4'b0000;
      for (int k = 0; k < N; k++) s = gf16_mul_const(s, ap[j]) ^ last_cw[k];
      check($sformatf("%s_S%0d", tag, j + 1), s, 4'b0000);
    end
  endtask

  task automatic compare_ref(input string tag);
    for (int i = 0; i < N; i++) check($sformatf("%s_sym%0d", tag, i), last_cw[i], ref_cw[i]);
  endtask

  initial begin
    int v0, e0, w0, a0;
    logic [0:3] par[NPAR];

    // reset state
    #12;
    check("rst_out", code_out, 4'b0000);
    check("rst_valid", code_valid, 1'b0);
    check("rst_sop", code_sop, 1'b0);
    check("rst_eop", code_eop, 1'b0);
    check("rst_eow", end_of_work, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    step();
    check("rdy_after_rst", in_ready, 1'b1);

    // single alpha^0 in the last position: parity equals g(x) coefficients
    for (int i = 0; i < K; i++) msg[i] = 4'b0000;
    msg[K-1] = 4'b1000;
    v0 = n_vld;
    send_msg(msg, 0);
    drain("t1");
    check("t1_nvalid", n_vld - v0, N);
    check("t1_sop_cyc", sop_cyc, acc_cyc);
    check("t1_eop_cyc", eop_cyc, acc_cyc + 14);
    check("t1_eow_cyc", eow_cyc, acc_cyc + 15);
    par = '{4'b1011, 4'b0011, 4'b0001, 4'b1110};
    for (int j = 0; j < NPAR; j++) check($sformatf("t1_par%0d", j), last_cw[K+j], par[j]);

    // single alpha^2
    msg[K-1] = 4'b0010;
    send_msg(msg, 0);
    drain("t2");
    par = '{4'b1000, 4'b1010, 4'b0110, 4'b1111};
    for (int j = 0; j < NPAR; j++) check($sformatf("t2_par%0d", j), last_cw[K+j], par[j]);

    // reference message, gapless then with gaps
    send_msg(msg3, 0);
    drain("t3a");
    check_syndromes("t3a");
    for (int i = 0; i < N; i++) ref_cw[i] = last_cw[i];
    v0 = n_vld;
    send_msg(msg3, 40);
    drain("t3b");
    check("t3b_nvalid", n_vld - v0, N);
    check_syndromes("t3b");
    compare_ref("t3b");

    // all-zero message
    for (int i = 0; i < K; i++) msg[i] = 4'b0000;
    send_msg(msg, 0);
    drain("t6");
    for (int i = 0; i < N; i++) check($sformatf("t6_sym%0d", i), last_cw[i], 4'b0000);

    // random messages with random gaps
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < K; i++) msg[i] = 4'($urandom);
      send_msg(msg, 30);
      drain($sformatf("rnd%0d", r));
      check_syndromes($sformatf("rnd%0d", r));
    end

    // in_valid held high for 40 cycles
    e0 = n_eop; w0 = n_eow; a0 = n_acc;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1;
      data_in  = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    check("t4_eops", n_eop - e0, 2);
    check("t4_eows", n_eow - w0, 2);
    check("t4_accepted", n_acc - a0, 28);
    check("t4_partial", msg_q.size(), 6);

    // asynchronous reset right after the 6th symbol of the partial codeword
    check("pre_rst_valid", code_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_out", code_out, 4'b0000);
    check("arst_valid", code_valid, 1'b0);
    check("arst_sop", code_sop, 1'b0);
    check("arst_eop", code_eop, 1'b0);
    check("arst_eow", end_of_work, 1'b0);
    msg_q.delete();
    exp_q.delete();
    // symbol offered as reset releases must not be taken on the first edge
    in_valid = 1'b1;
    data_in  = 4'b1111;
    @(negedge clk); rst_n = 1'b1;
    step();
    check("no_acc_first_edge", code_valid, 1'b0);
    in_valid = 1'b0;
    step();
    check("rdy_after_rst2", in_ready, 1'b1);
    send_msg(msg3, 0);
    drain("t5");
    compare_ref("t5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
